// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and data-stage ports share one memory
// command channel, with a single transaction outstanding at any time.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    // data-stage port
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_be,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    // shared memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int unsigned BE_W       = DATA_W / 8;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_dm;
    logic [3:0]          r_streak;
    logic                r_we;
    logic [BE_W-1:0]     r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_dm_win;
    logic                w_load;

    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Data wins unless fetch has been starved for MAX_STREAK grants.
    always_comb begin
        w_dm_win = dm_req && !(if_req && (r_streak == STREAK_MAX));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; everything forced quiet while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        mem_req     = 1'b0;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        dm_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rdata    = '0;
        busy        = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        w_load      = 1'b1;
                        w_state_nxt = CMD;
                    end
                end
                CMD: begin
                    busy    = 1'b1;
                    mem_req = 1'b1;
                    if_gnt  = !r_owner_dm && mem_gnt;
                    dm_gnt  = r_owner_dm && mem_gnt;
                    if (mem_gnt) begin
                        w_state_nxt = RSP;
                    end
                end
                RSP: begin
                    busy = 1'b1;
                    if (mem_rvalid) begin
                        if (r_owner_dm) begin
                            dm_rvalid = 1'b1;
                            dm_rdata  = mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Capture the winning command, owner and starvation streak at arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_dm <= 1'b0;
            r_streak   <= 4'd0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_load) begin
            r_owner_dm <= w_dm_win;
            if (w_dm_win) begin
                r_we    <= dm_we;
                r_be    <= dm_be;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
                if (if_req) begin
                    r_streak <= (r_streak < STREAK_MAX) ? r_streak + 4'd1 : STREAK_MAX;
                end else begin
                    r_streak <= 4'd0;
                end
            end else begin
                r_we     <= 1'b0;
                r_be     <= '1;
                r_addr   <= if_addr;
                r_wdata  <= '0;
                r_streak <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected transactions
// plus a cycle-accurate memory responder with programmable wait states.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [BW-1:0] dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid, busy;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          dm;
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct {
        bit            ok;
        int            lat;
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            stable;
        bit            spur_gnt;
        bit            spur_rv;
        bit            req_in_rsp;
        logic          gif, gdm, rvif, rvdm;
        logic [DW-1:0] rdif, rddm;
    } obs_t;

    txn_t sb[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory responder: waits for mem_req, grants after gdly stall cycles and
    // responds rdly cycles after the grant. Called just after a rising edge.
    task automatic serve(input int gdly, input int rdly, input logic [DW-1:0] rdata,
                         input bit both, output obs_t o);
        o = '{default: 0};
        while (mem_req !== 1'b1 && o.lat < 20) begin
            @(posedge clk); #1;
            o.lat++;
        end
        if (mem_req !== 1'b1) return;
        o.ok = 1; o.stable = 1;
        o.we = mem_we; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata;
        for (int k = 0; k < gdly; k++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== o.addr || mem_we !== o.we ||
                mem_be !== o.be || mem_wdata !== o.wdata) o.stable = 0;
            if (if_gnt || dm_gnt) o.spur_gnt = 1;
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        if (both) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
        end
        @(negedge clk);
        o.gif = if_gnt; o.gdm = dm_gnt;
        if (if_rvalid || dm_rvalid) o.spur_rv = 1;
        if (mem_req !== 1'b1 || mem_addr !== o.addr) o.stable = 0;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        if (o.gif === 1'b1) if_req = 1'b0;
        if (o.gdm === 1'b1) dm_req = 1'b0;
        for (int k = 1; k < rdly; k++) begin
            @(negedge clk);
            if (if_rvalid || dm_rvalid) o.spur_rv = 1;
            if (if_gnt || dm_gnt) o.spur_gnt = 1;
            if (mem_req) o.req_in_rsp = 1;
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        o.rvif = if_rvalid; o.rvdm = dm_rvalid; o.rdif = if_rdata; o.rddm = dm_rdata;
        if (mem_req) o.req_in_rsp = 1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h111; dm_addr = 32'h222;
        dm_we = 1'b1; dm_be = 4'hF; dm_wdata = 32'h3333;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy});
        end
        checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0 || mem_be !== '0 || mem_wdata !== '0 ||
            if_rdata !== '0 || dm_rdata !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got addr %h we %b be %h wdata %h want all zero",
                     mem_addr, mem_we, mem_be, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: got %b want 000000",
                     {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy});
        end
        if_req = 1'b0; dm_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        obs_t o;
        txn_t e;
        if_req = 1'b1; if_addr = 32'h100;
        sb.push_back('{1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h13});
        serve(0, 1, 32'h13, 0, o);
        e = sb.pop_front();
        checks++;
        if (!o.ok || o.lat != 1) begin
            errors++;
            $display("FAIL fetch_latency: got ok %0d lat %0d want ok 1 lat 1", o.ok, o.lat);
        end
        checks++;
        if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be || o.wdata !== e.wdata) begin
            errors++;
            $display("FAIL fetch_cmd: got %h/%b/%h/%h want %h/%b/%h/%h",
                     o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
        end
        checks++;
        if (o.gif !== 1'b1 || o.gdm !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt: got if %b dm %b want if 1 dm 0", o.gif, o.gdm);
        end
        checks++;
        if (o.rvif !== 1'b1 || o.rdif !== e.rdata || o.rvdm !== 1'b0 || o.rddm !== '0) begin
            errors++;
            $display("FAIL fetch_rsp: got rv %b data %h want rv 1 data %h",
                     o.rvif, o.rdif, e.rdata);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_busy_done: got %b want 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        obs_t o;
        txn_t e;
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'h0;
        sb.push_back('{1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE_0001});
        sb.push_back('{1'b0, 1'b0, 4'hF, 32'h200, 32'h0, 32'h0000_0093});
        for (int i = 0; i < 2; i++) begin
            serve(0, 1, sb[0].rdata, 0, o);
            e = sb.pop_front();
            checks++;
            if (!o.ok || o.gdm !== e.dm || o.gif !== ~e.dm || o.addr !== e.addr) begin
                errors++;
                $display("FAIL prio_order[%0d]: got gif %b gdm %b addr %h want dm %b addr %h",
                         i, o.gif, o.gdm, o.addr, e.dm, e.addr);
            end
            checks++;
            if ((e.dm ? o.rddm : o.rdif) !== e.rdata || (e.dm ? o.rdif : o.rddm) !== '0 ||
                o.rvdm !== e.dm || o.rvif !== ~e.dm) begin
                errors++;
                $display("FAIL prio_rsp[%0d]: got if %b/%h dm %b/%h want owner data %h",
                         i, o.rvif, o.rdif, o.rvdm, o.rddm, e.rdata);
            end
            checks++;
            if (o.req_in_rsp || o.lat != 1) begin
                errors++;
                $display("FAIL prio_overlap[%0d]: got req_in_rsp %0d lat %0d want 0 1",
                         i, o.req_in_rsp, o.lat);
            end
        end
    endtask

    task automatic test_streak();
        obs_t o;
        txn_t e;
        int   st = 0;
        for (int i = 0; i < 10; i++) begin
            if (!dm_req) begin
                dm_we = 1'b1; dm_be = 4'b0101;
                dm_addr = 32'h3000 + 32'(i * 4); dm_wdata = 32'hA500_0000 | 32'(i);
                dm_req = 1'b1;
            end
            if (!if_req) begin
                if_addr = 32'h400; if_req = 1'b1;
            end
            if (st == MS) begin
                sb.push_back('{1'b0, 1'b0, 4'hF, 32'h400, 32'h0, 32'h13 + 32'(i)});
                st = 0;
            end else begin
                sb.push_back('{1'b1, 1'b1, 4'b0101, dm_addr, dm_wdata, 32'h0});
                st++;
            end
            serve(0, 1, sb[0].rdata, 0, o);
            e = sb.pop_front();
            checks++;
            if (!o.ok || o.gdm !== e.dm || o.gif !== ~e.dm) begin
                errors++;
                $display("FAIL streak_owner[%0d]: got gif %b gdm %b want dm %b",
                         i, o.gif, o.gdm, e.dm);
            end
            checks++;
            if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be || o.wdata !== e.wdata ||
                o.rvdm !== e.dm || o.rvif !== ~e.dm) begin
                errors++;
                $display("FAIL streak_cmd[%0d]: got %h/%b/%h/%h want %h/%b/%h/%h",
                         i, o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        obs_t o;
        txn_t e;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h5000;
        dm_wdata = 32'hDEAD_BEEF;
        sb.push_back('{1'b1, 1'b1, 4'b0011, 32'h5000, 32'hDEAD_BEEF, 32'h0});
        serve(3, 5, 32'h0, 1, o);
        e = sb.pop_front();
        checks++;
        if (!o.ok || !o.stable || o.addr !== e.addr || o.wdata !== e.wdata ||
            o.be !== e.be || o.we !== e.we) begin
            errors++;
            $display("FAIL wait_cmd_stable: got ok %0d stable %0d addr %h want stable at %h",
                     o.ok, o.stable, o.addr, e.addr);
        end
        checks++;
        if (o.spur_gnt || o.gdm !== 1'b1 || o.gif !== 1'b0) begin
            errors++;
            $display("FAIL wait_gnt: got spurious %0d gdm %b gif %b want 0 1 0",
                     o.spur_gnt, o.gdm, o.gif);
        end
        checks++;
        if (o.spur_rv || o.rvdm !== 1'b1 || o.rvif !== 1'b0 || o.req_in_rsp) begin
            errors++;
            $display("FAIL wait_rvalid: got spurious %0d rvdm %b rvif %b want 0 1 0",
                     o.spur_rv, o.rvdm, o.rvif);
        end
    endtask

    task automatic test_reset_in_rsp();
        int n = 0;
        if_req = 1'b1; if_addr = 32'h600;
        while (mem_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstrsp_busy_before: got %b want 1", busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstrsp_during: got busy %b mem_req %b want 0 0", busy, mem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || busy !== 1'b0 || if_rdata !== '0) begin
            errors++;
            $display("FAIL rstrsp_stray: got if_rv %b dm_rv %b busy %b data %h want 0 0 0 0",
                     if_rvalid, dm_rvalid, busy, if_rdata);
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_stray_idle();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !== 6'b0 ||
                if_rdata !== '0 || dm_rdata !== '0) begin
                errors++;
                $display("FAIL stray_idle[%0d]: got %b want 000000", i,
                         {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy});
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_streak();
        test_wait_states();
        test_reset_in_rsp();
        test_stray_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width SHALL be DATA_W/8.
REQ-003 Parameter MAX_STREAK, default 4, consecutive data grants allowed while fetch waits; legal range 1-15.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 if_req  input  1  fetch request; held with if_addr stable until if_gnt.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_gnt  output  1  fetch request accepted by memory.
REQ-009 if_rvalid  output  1  fetch read data valid, one-cycle pulse.
REQ-010 if_rdata  output  DATA_W  fetch read data.
REQ-011 dm_req, dm_we, dm_be, dm_addr, dm_wdata  input  1/1/DATA_W/8/ADDR_W/DATA_W  data-stage request, write flag, byte enables, address, write data; held stable until dm_gnt.
REQ-012 dm_gnt, dm_rvalid, dm_rdata  output  1/1/DATA_W  data-stage accept, response pulse, read data.
REQ-013 mem_req, mem_we, mem_be, mem_addr, mem_wdata  output  1/1/DATA_W/8/ADDR_W/DATA_W  shared memory command.
REQ-014 mem_gnt  input  1  memory accepts command when mem_req && mem_gnt.
REQ-015 mem_rvalid, mem_rdata  input  1/DATA_W  memory response (reads and write acks).
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 FSM states IDLE, CMD, RSP; exactly one transaction outstanding at any time.
REQ-018 IDLE: if any request, arbitrate, register winner's command and owner, go CMD next cycle; else stay.
REQ-019 Arbitration: data wins over fetch, except fetch wins when both request and streak counter == MAX_STREAK.
REQ-020 Streak counter (4-bit): +1 on a data win with if_req high; cleared on a fetch win or a data win with if_req low; never exceeds MAX_STREAK.
REQ-021 CMD: mem_req=1 with registered command (mem_we=0, mem_be all-ones, mem_wdata=0 for fetch); on mem_gnt go RSP.
REQ-022 Owner's gnt (if_gnt or dm_gnt) SHALL equal mem_gnt combinationally in CMD for exactly that cycle; non-owner gnt stays 0.
REQ-023 RSP: mem_req=0; on mem_rvalid drive owner's rvalid=1 combinationally that cycle, owner's rdata=mem_rdata, go IDLE.
REQ-024 Write acks SHALL pulse dm_rvalid; dm_rdata content on write ack is don't-care.
REQ-025 mem_gnt outside CMD and mem_rvalid outside RSP SHALL be ignored with no state change.
REQ-026 mem_gnt and mem_rvalid in same cycle during CMD: treat as gnt only; response consumed in RSP.
REQ-027 Minimum latency: request at cycle N -> mem_req at N+1 -> gnt at N+1 -> rvalid at N+2; next arbitration at N+3.
REQ-028 Requester dropping req before gnt is a protocol violation; arbiter SHALL still complete the registered transaction.
REQ-029 if_rdata/dm_rdata outside their rvalid SHALL be 0.

Reset
REQ-030 rst high at a clock edge: state=IDLE, streak=0, owner=fetch, registered command zeroed.
REQ-031 During reset and the first cycle after: mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy = 0.
REQ-032 Reset mid-transaction SHALL abandon it; a later mem_rvalid SHALL be ignored.

Verification
REQ-033 Fetch only: if_req, if_addr=0x100, mem_gnt/mem_rvalid immediate, mem_rdata=0x00000013 -> mem_addr=0x100 at N+1, if_gnt N+1, if_rvalid with 0x13 at N+2, busy low at N+3.
REQ-034 Simultaneous if_req and dm_req (read 0x2000) -> data served first, fetch granted next; no overlap of mem_req transactions.
REQ-035 dm_req write continuously with if_req, MAX_STREAK=4 -> 4 data grants, 5th grant to fetch, counter then 0.
REQ-036 Wait states: mem_gnt delayed 3 cycles, mem_rvalid delayed 5 -> mem_req and command stable throughout CMD; single gnt and single rvalid pulse.
REQ-037 rst asserted in RSP, then stray mem_rvalid -> no rvalid pulse to either requester, busy=0.
REQ-038 Stray mem_rvalid and mem_gnt in IDLE -> no outputs toggle, state stays IDLE.
